// File: rtl/exec_wr_scoreboard.sv
// In-order write scoreboard: compares captured EXEC memory writes against an expected FIFO
// filled by a golden model, with saturating counters and sticky error flags.
module exec_wr_scoreboard #(
  parameter int ADDR_WIDTH  = 12,
  parameter int DATA_WIDTH  = 12,
  parameter int DEPTH       = 8,
  parameter int TIMEOUT     = 64,
  parameter int WR_DATA_LAT = 1,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       exp_valid,
  input  logic [ADDR_WIDTH-1:0]      exp_addr,
  input  logic [DATA_WIDTH-1:0]      exp_data,
  output logic                       exp_ready,
  input  logic                       exec_wr_req,
  input  logic [ADDR_WIDTH-1:0]      exec_wr_addr,
  input  logic [DATA_WIDTH-1:0]      exec_wr_data,
  input  logic                       sticky_clr,
  output logic                       match,
  output logic                       mismatch,
  output logic [ADDR_WIDTH-1:0]      err_addr,
  output logic [DATA_WIDTH-1:0]      err_exp_data,
  output logic [DATA_WIDTH-1:0]      err_obs_data,
  output logic [CNT_WIDTH-1:0]       match_cnt,
  output logic [CNT_WIDTH-1:0]       mismatch_cnt,
  output logic                       overflow,
  output logic                       unexpected,
  output logic                       timeout,
  output logic [$clog2(DEPTH):0]     fifo_level
);

  localparam int PW    = $clog2(DEPTH);
  localparam int LW    = PW + 1;
  localparam int AGE_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [LW-1:0]    DEPTH_L = LW'(DEPTH);
  localparam logic [AGE_W-1:0] TO_VAL  = AGE_W'(TIMEOUT);

  logic [ADDR_WIDTH-1:0] addr_mem [DEPTH];
  logic [DATA_WIDTH-1:0] data_mem [DEPTH];

  logic [PW-1:0]         wr_ptr_q, rd_ptr_q;
  logic [LW-1:0]         level_q, level_d;
  logic [AGE_W-1:0]      age_q, age_d;
  logic                  cmp_valid_q;
  logic [ADDR_WIDTH-1:0] cmp_addr_q;
  logic [DATA_WIDTH-1:0] cmp_data_q;
  logic                  match_q, mismatch_q;
  logic [ADDR_WIDTH-1:0] err_addr_q, err_addr_d;
  logic [DATA_WIDTH-1:0] err_exp_q, err_exp_d, err_obs_q, err_obs_d;
  logic [CNT_WIDTH-1:0]  match_cnt_q, match_cnt_d, mismatch_cnt_q, mismatch_cnt_d;
  logic                  overflow_q, overflow_d, unexpected_q, unexpected_d;
  logic                  timeout_q, timeout_d;

  logic fifo_empty, pop, push, hit, match_ev, mismatch_ev, unexp_ev, ovf_ev, to_ev;

  // Capture pipeline: the compare stage holds one fully assembled write.
  generate
    if (WR_DATA_LAT == 0) begin : g_lat0
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          cmp_valid_q <= 1'b0;
          cmp_addr_q  <= '0;
          cmp_data_q  <= '0;
        end else begin
          cmp_valid_q <= exec_wr_req;
          if (exec_wr_req) begin
            cmp_addr_q <= exec_wr_addr;
            cmp_data_q <= exec_wr_data;
          end
        end
      end
    end else begin : g_lat1
      logic                  cap_valid_q;
      logic [ADDR_WIDTH-1:0] cap_addr_q;
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          cap_valid_q <= 1'b0;
          cap_addr_q  <= '0;
          cmp_valid_q <= 1'b0;
          cmp_addr_q  <= '0;
          cmp_data_q  <= '0;
        end else begin
          cap_valid_q <= exec_wr_req;
          if (exec_wr_req) cap_addr_q <= exec_wr_addr;
          cmp_valid_q <= cap_valid_q;
          if (cap_valid_q) begin
            cmp_addr_q <= cap_addr_q;
            cmp_data_q <= exec_wr_data;
          end
        end
      end
    end
  endgenerate

  assign fifo_empty  = (level_q == '0);
  assign pop         = cmp_valid_q && !fifo_empty;
  assign exp_ready   = (level_q < DEPTH_L) || pop;
  assign push        = exp_valid && exp_ready;
  assign ovf_ev      = exp_valid && !exp_ready;
  assign hit         = (addr_mem[rd_ptr_q] == cmp_addr_q) && (data_mem[rd_ptr_q] == cmp_data_q);
  assign match_ev    = pop && hit;
  assign mismatch_ev = pop && !hit;
  assign unexp_ev    = cmp_valid_q && fifo_empty;

  always_ff @(posedge clk) begin
    if (push) begin
      addr_mem[wr_ptr_q] <= exp_addr;
      data_mem[wr_ptr_q] <= exp_data;
    end
  end

  always_comb begin
    level_d = level_q;
    if (push && !pop)      level_d = level_q + LW'(1);
    else if (!push && pop) level_d = level_q - LW'(1);

    age_d = age_q;
    if (TIMEOUT == 0 || pop || fifo_empty) age_d = '0;
    else if (age_q != TO_VAL)              age_d = age_q + AGE_W'(1);
    to_ev = (TIMEOUT != 0) && (age_d == TO_VAL);

    // A flag-setting event in the same cycle as sticky_clr takes priority.
    overflow_d   = (overflow_q   && !sticky_clr) || ovf_ev;
    unexpected_d = (unexpected_q && !sticky_clr) || unexp_ev;
    timeout_d    = (timeout_q    && !sticky_clr) || to_ev;

    match_cnt_d = match_cnt_q;
    if (match_ev)        match_cnt_d = sticky_clr ? CNT_WIDTH'(1)
                                     : ((&match_cnt_q) ? match_cnt_q : match_cnt_q + CNT_WIDTH'(1));
    else if (sticky_clr) match_cnt_d = '0;

    mismatch_cnt_d = mismatch_cnt_q;
    if (mismatch_ev)     mismatch_cnt_d = sticky_clr ? CNT_WIDTH'(1)
                                        : ((&mismatch_cnt_q) ? mismatch_cnt_q : mismatch_cnt_q + CNT_WIDTH'(1));
    else if (sticky_clr) mismatch_cnt_d = '0;

    err_addr_d = err_addr_q;
    err_exp_d  = err_exp_q;
    err_obs_d  = err_obs_q;
    if (mismatch_ev) begin
      err_addr_d = cmp_addr_q;
      err_exp_d  = data_mem[rd_ptr_q];
      err_obs_d  = cmp_data_q;
    end else if (sticky_clr) begin
      err_addr_d = '0;
      err_exp_d  = '0;
      err_obs_d  = '0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      level_q        <= '0;
      age_q          <= '0;
      match_q        <= 1'b0;
      mismatch_q     <= 1'b0;
      err_addr_q     <= '0;
      err_exp_q      <= '0;
      err_obs_q      <= '0;
      match_cnt_q    <= '0;
      mismatch_cnt_q <= '0;
      overflow_q     <= 1'b0;
      unexpected_q   <= 1'b0;
      timeout_q      <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      level_q        <= level_d;
      age_q          <= age_d;
      match_q        <= match_ev;
      mismatch_q     <= mismatch_ev;
      err_addr_q     <= err_addr_d;
      err_exp_q      <= err_exp_d;
      err_obs_q      <= err_obs_d;
      match_cnt_q    <= match_cnt_d;
      mismatch_cnt_q <= mismatch_cnt_d;
      overflow_q     <= overflow_d;
      unexpected_q   <= unexpected_d;
      timeout_q      <= timeout_d;
    end
  end

  assign match        = match_q;
  assign mismatch     = mismatch_q;
  assign err_addr     = err_addr_q;
  assign err_exp_data = err_exp_q;
  assign err_obs_data = err_obs_q;
  assign match_cnt    = match_cnt_q;
  assign mismatch_cnt = mismatch_cnt_q;
  assign overflow     = overflow_q;
  assign unexpected   = unexpected_q;
  assign timeout      = timeout_q;
  assign fifo_level   = level_q;

endmodule

// File: tb/tb_exec_wr_scoreboard.sv
// Scoreboard bench for exec_wr_scoreboard: a transaction-level queue model predicts results,
// a negedge monitor compares every DUT pulse, flag and counter against it.
module tb_exec_wr_scoreboard;
  localparam int AW = 12, DW = 12, DEPTH = 8, TO = 64, LAT = 1, CW = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic clk = 1'b0, reset_n = 1'b1;
  logic exp_valid = 0, exec_wr_req = 0, sticky_clr = 0;
  logic [AW-1:0] exp_addr = '0, exec_wr_addr = '0;
  logic [DW-1:0] exp_data = '0, exec_wr_data = '0;
  logic exp_ready, match, mismatch, overflow, unexpected, timeout;
  logic [AW-1:0] err_addr;
  logic [DW-1:0] err_exp_data, err_obs_data;
  logic [CW-1:0] match_cnt, mismatch_cnt;
  logic [$clog2(DEPTH):0] fifo_level;

  exec_wr_scoreboard #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH), .TIMEOUT(TO),
                       .WR_DATA_LAT(LAT), .CNT_WIDTH(CW)) dut (
    .clk(clk), .reset_n(reset_n), .exp_valid(exp_valid), .exp_addr(exp_addr), .exp_data(exp_data),
    .exp_ready(exp_ready), .exec_wr_req(exec_wr_req), .exec_wr_addr(exec_wr_addr),
    .exec_wr_data(exec_wr_data), .sticky_clr(sticky_clr), .match(match), .mismatch(mismatch),
    .err_addr(err_addr), .err_exp_data(err_exp_data), .err_obs_data(err_obs_data),
    .match_cnt(match_cnt), .mismatch_cnt(mismatch_cnt), .overflow(overflow),
    .unexpected(unexpected), .timeout(timeout), .fifo_level(fifo_level));

  always #5 clk = ~clk;

  typedef struct { logic [AW-1:0] a; logic [DW-1:0] d; } ent_t;
  typedef struct { logic [AW-1:0] a; logic [DW-1:0] d; int dcyc; int due; } pend_t;
  typedef struct { bit is_mm; logic [AW-1:0] a; logic [DW-1:0] ed; logic [DW-1:0] od; } res_t;

  ent_t  mq[$];
  pend_t pq[$];
  res_t  rq[$];
  int cyc = 0, m_age = 0, m_mcnt = 0, m_mmcnt = 0;
  bit m_ovf = 0, m_unx = 0, m_to = 0;
  logic [AW-1:0] m_ea = '0;
  logic [DW-1:0] m_eed = '0, m_eod = '0;

  int vectors = 0, fails = 0;
  logic [DW-1:0] nxt_d = '0;

  task automatic chk(input string nm, input longint act, input longint exp);
    vectors++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: one update per clock, built directly from the queue semantics.
  initial begin
    bit pop, mev, mmev, uev, oev, tev;
    int sz0;
    pend_t p;
    ent_t h;
    forever begin
      @(posedge clk or negedge reset_n);
      if (!reset_n) begin
        mq.delete(); pq.delete(); rq.delete();
        cyc = 0; m_age = 0; m_mcnt = 0; m_mmcnt = 0;
        m_ovf = 0; m_unx = 0; m_to = 0; m_ea = '0; m_eed = '0; m_eod = '0;
        continue;
      end
      pop = 0; mev = 0; mmev = 0; uev = 0; oev = 0; tev = 0;
      sz0 = mq.size();
      if (pq.size() > 0 && pq[0].due == cyc) begin
        p = pq.pop_front();
        if (sz0 > 0) begin
          h = mq.pop_front();
          pop = 1;
          if (h.a == p.a && h.d == p.d) begin
            mev = 1;
            rq.push_back('{0, p.a, h.d, p.d});
          end else begin
            mmev = 1;
            rq.push_back('{1, p.a, h.d, p.d});
          end
        end else uev = 1;
      end
      foreach (pq[i]) if (pq[i].dcyc == cyc) pq[i].d = exec_wr_data;
      if (exec_wr_req) pq.push_back('{exec_wr_addr, exec_wr_data, cyc + LAT, cyc + 1 + LAT});
      if (exp_valid) begin
        if (sz0 < DEPTH || pop) mq.push_back('{exp_addr, exp_data});
        else oev = 1;
      end
      if (pop || sz0 == 0) m_age = 0;
      else if (m_age < TO) m_age++;
      tev = (m_age == TO);
      m_ovf = (m_ovf && !sticky_clr) || oev;
      m_unx = (m_unx && !sticky_clr) || uev;
      m_to  = (m_to  && !sticky_clr) || tev;
      if (mev) m_mcnt = sticky_clr ? 1 : ((m_mcnt < CMAX) ? m_mcnt + 1 : CMAX);
      else if (sticky_clr) m_mcnt = 0;
      if (mmev) m_mmcnt = sticky_clr ? 1 : ((m_mmcnt < CMAX) ? m_mmcnt + 1 : CMAX);
      else if (sticky_clr) m_mmcnt = 0;
      if (mmev) begin
        m_ea = p.a; m_eed = h.d; m_eod = p.d;
      end else if (sticky_clr) begin
        m_ea = '0; m_eed = '0; m_eod = '0;
      end
      cyc++;
    end
  end

  // Monitor: any expected result must appear as a pulse exactly on this negedge.
  initial begin
    res_t r;
    bit exp_rdy;
    forever begin
      @(negedge clk);
      chk("pulse", match | mismatch, rq.size() > 0);
      if ((match | mismatch) && rq.size() > 0) begin
        r = rq.pop_front();
        chk("excl", match & mismatch, 0);
        chk("kind_mismatch", mismatch, r.is_mm);
        if (r.is_mm) begin
          chk("err_addr", err_addr, r.a);
          chk("err_exp_data", err_exp_data, r.ed);
          chk("err_obs_data", err_obs_data, r.od);
        end
      end
      exp_rdy = (mq.size() < DEPTH) || (pq.size() > 0 && pq[0].due == cyc && mq.size() > 0);
      chk("exp_ready", exp_ready, exp_rdy);
      chk("fifo_level", fifo_level, mq.size());
      chk("overflow", overflow, m_ovf);
      chk("unexpected", unexpected, m_unx);
      chk("timeout", timeout, m_to);
      chk("match_cnt", match_cnt, m_mcnt);
      chk("mismatch_cnt", mismatch_cnt, m_mmcnt);
      chk("err_addr_hold", err_addr, m_ea);
    end
  end

  task automatic step(input bit ev, input logic [AW-1:0] ea, input logic [DW-1:0] ed,
                      input bit rqv, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                      input bit clr);
    @(negedge clk);
    exp_valid = ev; exp_addr = ea; exp_data = ed;
    exec_wr_req = rqv; exec_wr_addr = wa; sticky_clr = clr;
    if (LAT == 0) exec_wr_data = wd;
    else begin
      exec_wr_data = nxt_d;
      nxt_d = rqv ? wd : '0;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, '0, '0, 0, '0, '0, 0);
  endtask
  task automatic push(input logic [AW-1:0] a, input logic [DW-1:0] d);
    step(1, a, d, 0, '0, '0, 0);
  endtask
  task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
    step(0, '0, '0, 1, a, d, 0);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_exp_ready"}, exp_ready, 1);
    chk({tag, "_level"}, fifo_level, 0);
    chk({tag, "_pulses"}, {match, mismatch}, 0);
    chk({tag, "_flags"}, {overflow, unexpected, timeout}, 0);
    chk({tag, "_cnts"}, {match_cnt, mismatch_cnt}, 0);
    chk({tag, "_err"}, {err_addr, err_exp_data, err_obs_data}, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    logic [AW-1:0] wa;
    logic [DW-1:0] wd;
    #1 reset_n = 1'b0;
    idle(3);
    reset_n = 1'b1;
    #1 chk_reset_vals("reset");

    push(12'h100, 12'h001); push(12'h101, 12'h002); push(12'h102, 12'h7FF);
    wr(12'h100, 12'h001); wr(12'h101, 12'h002); wr(12'h102, 12'h7FF);
    idle(5);
    #1 chk("t1_match_cnt", match_cnt, 3);
    chk("t1_level", fifo_level, 0);
    chk("t1_flags", {overflow, unexpected, timeout}, 0);

    push(12'h200, 12'h0AB);
    wr(12'h200, 12'h0AC);
    idle(4);
    #1 chk("t2_err_addr", err_addr, 12'h200);
    chk("t2_err_exp", err_exp_data, 12'h0AB);
    chk("t2_err_obs", err_obs_data, 12'h0AC);
    chk("t2_mismatch_cnt", mismatch_cnt, 1);

    for (int i = 0; i < DEPTH; i++) push(AW'(12'h300 + i), DW'(i));
    idle(1);
    #1 chk("t3_full_ready", exp_ready, 0);
    chk("t3_full_level", fifo_level, DEPTH);
    push(12'h3FF, 12'h3FF);
    idle(1);
    #1 chk("t3_overflow", overflow, 1);
    chk("t3_level_after_ovf", fifo_level, DEPTH);
    wr(12'h300, 12'h000);
    idle(1);
    push(12'h308, 12'h008);
    #1 chk("t3_ready_on_pop", exp_ready, 1);
    idle(1);
    #1 chk("t3_level_stays", fifo_level, DEPTH);
    for (int i = 1; i <= DEPTH; i++) wr(AW'(12'h300 + i), DW'(i));
    idle(5);
    #1 chk("t3_drained", fifo_level, 0);
    chk("t3_match_cnt_sat", match_cnt, (3 + 1 + DEPTH > CMAX) ? CMAX : 3 + 1 + DEPTH);

    wr(12'h050, 12'h123);
    idle(4);
    #1 chk("t4_unexpected", unexpected, 1);
    step(0, '0, '0, 0, '0, '0, 1);
    idle(1);
    #1 chk("t4_clr_flags", {overflow, unexpected, timeout}, 0);
    chk("t4_clr_cnts", {match_cnt, mismatch_cnt}, 0);
    chk("t4_clr_err", {err_addr, err_exp_data, err_obs_data}, 0);

    push(12'h400, 12'h055);
    idle(60);
    #1 chk("t5_no_timeout_yet", timeout, 0);
    idle(10);
    #1 chk("t5_timeout", timeout, 1);
    wr(12'h400, 12'h055);
    idle(4);
    #1 chk("t5_late_match", match_cnt, 1);
    chk("t5_level", fifo_level, 0);

    for (int i = 0; i < 4; i++) push(AW'(12'h500 + i), DW'(12'h050 + i));
    wr(12'h500, 12'h050);
    idle(1);
    #2 reset_n = 1'b0;
    #1 chk_reset_vals("midreset");
    idle(2);
    reset_n = 1'b1;
    nxt_d = '0;
    push(12'h600, 12'h066);
    wr(12'h600, 12'h066);
    idle(5);
    #1 chk("t6_match_cnt", match_cnt, 1);
    chk("t6_mismatch_cnt", mismatch_cnt, 0);
    chk("t6_level", fifo_level, 0);

    for (int n = 0; n < 3000; n++) begin
      k = pq.size();
      if (k < mq.size() && $urandom_range(3) != 0) begin
        wa = mq[k].a; wd = mq[k].d;
      end else begin
        wa = AW'($urandom); wd = DW'($urandom);
      end
      step($urandom_range(99) < 40, AW'($urandom), DW'($urandom),
           $urandom_range(99) < 35, wa, wd, $urandom_range(99) < 1);
    end
    idle(10);
    #1 chk("end_result_queue_empty", rq.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end
endmodule

// File: doc/exec_wr_scoreboard.md
Name: exec_wr_scoreboard

Overview:
- Synthesizable, parametrised scoreboard for the EXEC unit's memory-write channel.
- A golden model pushes expected writes (address and data) into an in-order expected FIFO. The block captures the DUT's exec_wr_req/addr/data transactions and compares each one against the FIFO head.
- It reports per-transaction match/mismatch, saturating counters and sticky error flags (overflow, unexpected write, timeout).
- It sits beside instr_exec on the memory_pdp boundary in unit- and chip-level benches.

Parameters:
- ADDR_WIDTH, 12, width of write address.
- DATA_WIDTH, 12, width of write data.
- DEPTH, 8, expected-FIFO entries; power of 2, minimum 2.
- TIMEOUT, 64, maximum cycles the head entry may wait for a DUT write; 0 disables the timeout.
- WR_DATA_LAT, 1, cycles from exec_wr_req to valid exec_wr_data; legal values 0 or 1.
- CNT_WIDTH, 16, width of the match and mismatch counters.

Ports:
- clk  in  1  free-running clock.
- reset_n  in  1  asynchronous active-low reset.
- exp_valid  in  1  golden model push strobe.
- exp_addr  in  ADDR_WIDTH  expected write address.
- exp_data  in  DATA_WIDTH  expected write data.
- exp_ready  out  1  FIFO can accept a push this cycle.
- exec_wr_req  in  1  DUT write request (one-cycle pulse per write).
- exec_wr_addr  in  ADDR_WIDTH  DUT write address, valid with exec_wr_req.
- exec_wr_data  in  DATA_WIDTH  DUT write data, valid WR_DATA_LAT cycles after exec_wr_req.
- sticky_clr  in  1  synchronous clear of sticky flags and counters.
- match  out  1  one-cycle pulse: compared transaction equal.
- mismatch  out  1  one-cycle pulse: address or data differs.
- err_addr  out  ADDR_WIDTH  DUT address of the last mismatch.
- err_exp_data  out  DATA_WIDTH  expected data of the last mismatch.
- err_obs_data  out  DATA_WIDTH  DUT data of the last mismatch.
- match_cnt  out  CNT_WIDTH  saturating match count.
- mismatch_cnt  out  CNT_WIDTH  saturating mismatch count.
- overflow  out  1  sticky: push attempted while not exp_ready.
- unexpected  out  1  sticky: DUT write compared with an empty FIFO.
- timeout  out  1  sticky: head entry aged to TIMEOUT.
- fifo_level  out  $clog2(DEPTH)+1  current number of FIFO entries.

Behaviour:
- Reset (asynchronous, reset_n low):
  - All outputs 0 except exp_ready=1.
  - FIFO pointers and the age counter cleared.
  - The capture stage is emptied.
- Capture stage:
  - WR_DATA_LAT=0: address and data are registered on the exec_wr_req cycle; the compare happens the next cycle.
  - WR_DATA_LAT=1: exec_wr_addr is registered on the req cycle and exec_wr_data on the following cycle; the compare happens the cycle after that.
  - Back-to-back reqs are supported in both modes; the capture is a 2-entry pipeline, not a stall.
- Compare cycle:
  - FIFO non-empty: pop the head. match=1 if address and data are both equal, else mismatch=1 and the err_* registers are loaded.
  - FIFO empty: unexpected is set; no pop; neither match nor mismatch pulses.
- No bypass: an entry pushed in the same cycle as a compare is not visible to that compare.
- Push:
  - Accepted when exp_valid and exp_ready.
  - exp_ready = (level<DEPTH) or pop this cycle. A push while full with a simultaneous pop is accepted and the level stays at DEPTH.
  - exp_valid while not exp_ready: the data is dropped, overflow is set, and FIFO contents are unchanged.
- Pointers wrap modulo DEPTH; fifo_level reads 0..DEPTH.
- Age counter:
  - Cleared on every pop and whenever the FIFO is empty.
  - Otherwise increments each cycle, saturating at TIMEOUT.
  - On reaching TIMEOUT, timeout is set. The entry is not dropped; a later matching write still pops it and counts.
- Counters saturate at all-ones; no wrap.
- sticky_clr:
  - Clears overflow, unexpected, timeout, both counters and err_*.
  - Does not touch FIFO contents or the capture stage.
  - If an event occurs in the same cycle as sticky_clr, the event wins: the flag is set and the counter loads 1.
- match and mismatch are mutually exclusive and registered (they are outputs of the compare cycle).

Test Plan:
- Reset, then 3 pushes (0x100/0x001, 0x101/0x002, 0x102/0x7FF), then 3 matching DUT writes with WR_DATA_LAT=1 -> 3 match pulses, match_cnt=3, fifo_level=0, no flags set.
- Push 0x200/0x0AB; DUT writes 0x200/0x0AC -> mismatch pulse, err_addr=0x200, err_exp_data=0x0AB, err_obs_data=0x0AC, mismatch_cnt=1.
- DEPTH=8: push 8 entries (exp_ready drops), then a 9th push -> overflow=1, fifo_level=8. Next cycle, push together with a compare pop -> the push is accepted and the level stays 8.
- FIFO empty, DUT write 0x050/0x123 -> unexpected=1, no match/mismatch pulse. Then sticky_clr -> all flags and counters 0.
- TIMEOUT=64: push one entry and issue no write for 64 cycles -> timeout=1 at cycle 64. A later matching write -> match pulse and fifo_level=0.
- Assert reset_n low during a WR_DATA_LAT=1 capture with 4 entries queued -> all outputs are immediately at reset values. After release, a new push/write pair matches with no stale compare.
